pet_stat_engine: RTL and testbench

//   Parametrised stat engine for the pet core: N independent saturating stat channels.

---
 rtl/pet_stat_engine.sv | 202 ++++++++++++++++++++
 tb/tb_pet_stat_engine.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pet_stat_engine.sv
// pet_stat_engine: N saturating stat channels with prescaled decay, signed
// valid/ready adjust commands and an ALIVE/CRITICAL/DEAD life-cycle FSM.
// Optional feature macro: STATS_JITTER_EN (per-channel random decay from rand_bits).
module pet_stat_engine #(
  parameter int N_STATS     = 6,
  parameter int STAT_W      = 4,
  parameter int TICK_DIV    = 10_000_000,
  parameter int STAT_INIT   = (2 ** STAT_W) - 1,
  parameter int LOW_THR     = 3,
  parameter int DEATH_TICKS = 8,
  localparam int IDX_W      = (N_STATS > 1) ? $clog2(N_STATS) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_STATS-1:0]          rand_bits,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [IDX_W-1:0]            cmd_idx,
  input  logic [STAT_W:0]             cmd_delta,
  input  logic                        revive,
  output logic [N_STATS*STAT_W-1:0]   stats_flat,
  output logic [N_STATS-1:0]          low_flags,
  output logic [1:0]                  state,
  output logic                        tick,
  output logic                        cmd_err
);

  localparam int SMAX   = (2 ** STAT_W) - 1;
  localparam int PSC_W  = $clog2(TICK_DIV);
  localparam int CRIT_W = $clog2(DEATH_TICKS + 1);
  localparam int SUM_W  = STAT_W + 2;
  localparam logic [PSC_W-1:0]        PSC_MAX   = PSC_W'(TICK_DIV - 1);
  localparam logic [CRIT_W-1:0]       CRIT_LAST = CRIT_W'(DEATH_TICKS - 1);
  localparam logic [STAT_W-1:0]       INIT_V    = STAT_W'(STAT_INIT);
  localparam logic [STAT_W-1:0]       THR_V     = STAT_W'(LOW_THR);
  localparam logic [STAT_W-1:0]       SMAX_V    = STAT_W'(SMAX);
  localparam logic signed [SUM_W-1:0] SUM_MAX   = SUM_W'(SMAX);
  localparam logic [N_STATS-1:0]      INIT_LOW  =
    (STAT_INIT <= LOW_THR) ? {N_STATS{1'b1}} : {N_STATS{1'b0}};

  typedef enum logic [1:0] {
    ST_ALIVE = 2'd0,
    ST_CRIT  = 2'd1,
    ST_DEAD  = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [CRIT_W-1:0]         crit_q, crit_d;
  logic [STAT_W-1:0]         stat_q [N_STATS];
  logic [STAT_W-1:0]         stat_d [N_STATS];
  logic signed [SUM_W-1:0]   sum_s  [N_STATS];
  logic [PSC_W-1:0]          psc_q, psc_d;
  logic                      tick_q, tick_d;
  logic                      err_q, err_d;
  logic [N_STATS-1:0]        low_q, low_d, low_now_s;
  logic [N_STATS-1:0]        dec_en_s;
  logic                      dead_s, cmd_acc_s, revive_s;

`ifdef STATS_JITTER_EN
  // Random per-channel decay: a channel only loses a point when its bit is set.
  assign dec_en_s = rand_bits;
`else
  // Every channel decays every tick; rand_bits is a don't-care here.
  assign dec_en_s = rand_bits | {N_STATS{1'b1}};
`endif

  // FSM outputs: readiness, command acceptance and qualified revive.
  always_comb begin
    dead_s    = (state_q == ST_DEAD);
    cmd_ready = !dead_s;
    cmd_acc_s = cmd_valid && !dead_s;
    revive_s  = revive && dead_s;
  end

  // Per-channel next value: decay and command in wide signed math, then clamp.
  always_comb begin
    for (int i = 0; i < N_STATS; i++) begin
      sum_s[i] = $signed({2'b00, stat_q[i]});
      if (tick_q && dec_en_s[i]) begin
        sum_s[i] = sum_s[i] - $signed(SUM_W'(1));
      end else begin
        sum_s[i] = sum_s[i];
      end
      if (cmd_acc_s && (32'(cmd_idx) == i)) begin
        sum_s[i] = sum_s[i] + $signed({cmd_delta[STAT_W], cmd_delta});
      end else begin
        sum_s[i] = sum_s[i];
      end
      if (revive_s) begin
        stat_d[i] = INIT_V;
      end else if (sum_s[i][SUM_W-1]) begin
        stat_d[i] = {STAT_W{1'b0}};
      end else if (sum_s[i] > SUM_MAX) begin
        stat_d[i] = SMAX_V;
      end else begin
        stat_d[i] = sum_s[i][STAT_W-1:0];
      end
      low_now_s[i] = (stat_q[i] <= THR_V);
    end
  end

  // Prescaler, tick pulse, bad-index error pulse and low flags.
  always_comb begin
    if (revive_s) begin
      psc_d = {PSC_W{1'b0}};
    end else if (dead_s) begin
      psc_d = psc_q;
    end else if (psc_q == PSC_MAX) begin
      psc_d = {PSC_W{1'b0}};
    end else begin
      psc_d = psc_q + PSC_W'(1);
    end
    tick_d = !dead_s && (psc_q == PSC_MAX);
    err_d  = cmd_acc_s && (32'(cmd_idx) >= 32'(N_STATS));
    low_d  = revive_s ? INIT_LOW : low_now_s;
  end

  // Life-cycle next state, driven from the registered stats.
  always_comb begin
    state_d = state_q;
    crit_d  = crit_q;
    case (state_q)
      ST_ALIVE: begin
        if (|low_now_s) begin
          state_d = ST_CRIT;
          crit_d  = {CRIT_W{1'b0}};
        end else begin
          state_d = ST_ALIVE;
        end
      end
      ST_CRIT: begin
        if (!(|low_now_s)) begin
          state_d = ST_ALIVE;
          crit_d  = {CRIT_W{1'b0}};
        end else if (tick_q) begin
          crit_d = crit_q + CRIT_W'(1);
          if (crit_q == CRIT_LAST) begin
            state_d = ST_DEAD;
          end else begin
            state_d = ST_CRIT;
          end
        end else begin
          state_d = ST_CRIT;
        end
      end
      ST_DEAD: begin
        if (revive) begin
          state_d = ST_ALIVE;
          crit_d  = {CRIT_W{1'b0}};
        end else begin
          state_d = ST_DEAD;
        end
      end
      default: begin
        state_d = ST_ALIVE;
        crit_d  = {CRIT_W{1'b0}};
      end
    endcase
  end

  // Life-cycle state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ALIVE;
      crit_q  <= {CRIT_W{1'b0}};
    end else begin
      state_q <= state_d;
      crit_q  <= crit_d;
    end
  end

  // Datapath registers: stats, prescaler and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_STATS; i++) begin
        stat_q[i] <= INIT_V;
      end
      psc_q  <= {PSC_W{1'b0}};
      tick_q <= 1'b0;
      err_q  <= 1'b0;
      low_q  <= INIT_LOW;
    end else begin
      for (int i = 0; i < N_STATS; i++) begin
        stat_q[i] <= stat_d[i];
      end
      psc_q  <= psc_d;
      tick_q <= tick_d;
      err_q  <= err_d;
      low_q  <= low_d;
    end
  end

  for (genvar g = 0; g < N_STATS; g++) begin : g_flat
    assign stats_flat[g*STAT_W +: STAT_W] = stat_q[g];
  end

  assign low_flags = low_q;
  assign state     = state_q;
  assign tick      = tick_q;
  assign cmd_err   = err_q;

endmodule

// File: tb/tb_pet_stat_engine.sv
// Scoreboard bench for pet_stat_engine (N_STATS=6 STAT_W=4 TICK_DIV=4,
// STAT_INIT=15 LOW_THR=3 DEATH_TICKS=4). Expected values are queued when the
// stimulus is applied and popped when the DUT output is sampled (negedge).
module tb_pet_stat_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  rand_bits;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_idx;
  logic [4:0]  cmd_delta;
  logic        revive;
  logic [23:0] stats_flat;
  logic [5:0]  low_flags;
  logic [1:0]  state;
  logic        tick;
  logic        cmd_err;

`ifdef STATS_JITTER_EN
  localparam logic [5:0]  RB_ALL  = 6'h3F;
  localparam logic [23:0] JIT_EXP = 24'hFFFEFE;
`else
  localparam logic [5:0]  RB_ALL  = 6'h00;
  localparam logic [23:0] JIT_EXP = 24'hEEEEEE;
`endif

  always #5 clk = ~clk;

  pet_stat_engine #(
    .N_STATS(6), .STAT_W(4), .TICK_DIV(4),
    .STAT_INIT(15), .LOW_THR(3), .DEATH_TICKS(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rand_bits(rand_bits),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_idx(cmd_idx),
    .cmd_delta(cmd_delta), .revive(revive), .stats_flat(stats_flat),
    .low_flags(low_flags), .state(state), .tick(tick), .cmd_err(cmd_err)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   vec_cnt = 0;
  int   err_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val("sb_underflow", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_val(e.tag, obs, e.val);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_idx   = 3'd0;
    cmd_delta = 5'd0;
    revive    = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_tick();
    int n = 0;
    while (tick !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (tick !== 1'b1) check_val("tick_timeout", 32'(tick), 32'd1);
  endtask

  // Wait for the tick cycle, then let the decay edge happen.
  task automatic tick_step();
    wait_tick();
    step();
  endtask

  task automatic send_cmd(input logic [2:0] idx, input logic [4:0] d);
    cmd_valid = 1'b1;
    cmd_idx   = idx;
    cmd_delta = d;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int tcnt;
    rand_bits = RB_ALL;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_idx   = 3'd0;
    cmd_delta = 5'd0;
    revive    = 1'b0;

    // Reset values while reset is held.
    step();
    sb_push("rst_stats", 32'h00FFFFFF); sb_check(32'(stats_flat));
    sb_push("rst_state", 32'd0);        sb_check(32'(state));
    sb_push("rst_ready", 32'd1);        sb_check(32'(cmd_ready));
    sb_push("rst_tick",  32'd0);        sb_check(32'(tick));
    sb_push("rst_low",   32'd0);        sb_check(32'(low_flags));
    sb_push("rst_err",   32'd0);        sb_check(32'(cmd_err));

    // Tick timing: pulse in the cycle after the prescaler reaches 3.
    rst_n = 1'b1;
    repeat (3) step();
    sb_push("tick_pre", 32'd0);  sb_check(32'(tick));
    step();
    sb_push("tick_on", 32'd1);   sb_check(32'(tick));
    step();
    sb_push("tick_off", 32'd0);  sb_check(32'(tick));
    sb_push("decay1", 32'h00EEEEEE); sb_check(32'(stats_flat));

    // Saturation at both ends and bad index.
    do_reset();
    sb_push("sat_hi", 32'h00FFFFFF); send_cmd(3'd2, 5'd10);    sb_check(32'(stats_flat));
    sb_push("sat_lo", 32'h00FFF0FF); send_cmd(3'd2, 5'b10000); sb_check(32'(stats_flat));
    sb_push("err_on", 32'd1);
    sb_push("err_stats", 32'h00FFF0FF);
    send_cmd(3'd7, 5'd3);
    sb_check(32'(cmd_err));
    sb_check(32'(stats_flat));
    sb_push("err_off", 32'd0); step(); sb_check(32'(cmd_err));
    step();
    sb_push("sat_tick", 32'h00EEE0EE); sb_check(32'(stats_flat));
    sb_push("low_ch2",  32'h04);       sb_check(32'(low_flags));
    sb_push("crit_ch2", 32'd1);        sb_check(32'(state));

    // Same-cycle tick and command, then non-saturating signed adjustments.
    do_reset();
    repeat (5) tick_step();
    sb_push("ten", 32'h00AAAAAA); sb_check(32'(stats_flat));
    wait_tick();
    sb_push("tick_cmd", 32'h0099999A); send_cmd(3'd0, 5'd1);  sb_check(32'(stats_flat));
    sb_push("neg_cmd",  32'h0099799A); send_cmd(3'd3, 5'h1E); sb_check(32'(stats_flat));
    sb_push("pos_cmd",  32'h00C9799A); send_cmd(3'd5, 5'd3);  sb_check(32'(stats_flat));

    // Idle decay into CRITICAL, then DEAD.
    do_reset();
    repeat (12) tick_step();
    sb_push("idle_stats", 32'h00333333); sb_check(32'(stats_flat));
    sb_push("idle_low0",  32'd0);        sb_check(32'(low_flags));
    sb_push("idle_st0",   32'd0);        sb_check(32'(state));
    step();
    sb_push("idle_low1",  32'h3F);       sb_check(32'(low_flags));
    sb_push("idle_st1",   32'd1);        sb_check(32'(state));
    repeat (3) tick_step();
    sb_push("crit_hold",  32'd1);        sb_check(32'(state));
    sb_push("crit_zero",  32'h00000000); sb_check(32'(stats_flat));
    tick_step();
    sb_push("dead_st",    32'd2);        sb_check(32'(state));
    sb_push("dead_rdy",   32'd0);        sb_check(32'(cmd_ready));
    sb_push("dead_cmd",   32'h00000000); send_cmd(3'd1, 5'd5); sb_check(32'(stats_flat));
    tcnt = 0;
    repeat (12) begin
      step();
      if (tick === 1'b1) tcnt++;
    end
    sb_push("dead_ticks", 32'd0);        sb_check(32'(tcnt));
    sb_push("dead_keep",  32'd2);        sb_check(32'(state));

    // Revive from DEAD restores stats and restarts the prescaler.
    revive = 1'b1; step(); revive = 1'b0;
    sb_push("rev_stats", 32'h00FFFFFF); sb_check(32'(stats_flat));
    sb_push("rev_state", 32'd0);        sb_check(32'(state));
    sb_push("rev_ready", 32'd1);        sb_check(32'(cmd_ready));
    sb_push("rev_low",   32'd0);        sb_check(32'(low_flags));
    step();
    sb_push("rev_stay",  32'd0);        sb_check(32'(state));
    repeat (2) step();
    sb_push("rev_tick0", 32'd0);        sb_check(32'(tick));
    step();
    sb_push("rev_tick1", 32'd1);        sb_check(32'(tick));
    step();
    revive = 1'b1; step(); revive = 1'b0;
    sb_push("rev_alive", 32'h00EEEEEE); sb_check(32'(stats_flat));
    sb_push("rev_alst",  32'd0);        sb_check(32'(state));

    // Jitter pattern (only ch0/ch2 decay when the feature is built in).
    rand_bits = 6'b000101;
    do_reset();
    tick_step();
    sb_push("jitter", 32'(JIT_EXP)); sb_check(32'(stats_flat));

    // Asynchronous reset in the middle of a command discards it.
    send_cmd(3'd4, 5'h1B);
    cmd_valid = 1'b1; cmd_idx = 3'd0; cmd_delta = 5'h1B;
    rst_n = 1'b0;
    #1;
    sb_push("arst_stats", 32'h00FFFFFF); sb_check(32'(stats_flat));
    sb_push("arst_state", 32'd0);        sb_check(32'(state));
    sb_push("arst_low",   32'd0);        sb_check(32'(low_flags));
    step();
    sb_push("arst_hold",  32'h00FFFFFF); sb_check(32'(stats_flat));
    cmd_valid = 1'b0;
    rst_n = 1'b1;

    if (sb_q.size() != 0) check_val("sb_left", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
